// File: rtl/m_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : m_div_seq
// Description : Radix-2 restoring divider sequencer for RV32M DIV/DIVU/REM/REMU,
//               stepping the external m_alu subtractor one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif
`ifndef MUX_DIV_REM_Z
`define MUX_DIV_REM_Z 1'b0
`endif
`ifndef MUX_DIV_REM_R
`define MUX_DIV_REM_R 1'b1
`endif

module m_div_seq #(
    parameter int BYPASS_DIV0 = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [1:0]                     op,
    input  logic [31:0]                    rs1,
    input  logic [31:0]                    rs2,
    input  logic                           kill,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    result,
    output logic [31:0]                    R,
    output logic [62:0]                    D,
    output logic [31:0]                    Z,
    output logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
    input  logic [31:0]                    sub_result,
    input  logic                           sub_neg,
    input  logic [31:0]                    div_rem,
    input  logic [31:0]                    div_rem_neg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIX    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  op_q;
    logic        sa;
    logic        sb;
    logic        div0;
    logic [31:0] dividend;
    logic [4:0]  cnt;

    logic        in_sa;
    logic        in_sb;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        bypass;
    logic        neg_fix;
    logic [31:0] fix_value;

    // Magnitudes of the incoming operands; 0x80000000 negates to itself and
    // is then treated as an unsigned magnitude.
    assign in_sa  = ~op[0] & rs1[31];
    assign in_sb  = ~op[0] & rs2[31];
    assign abs_a  = in_sa ? (32'd0 - rs1) : rs1;
    assign abs_b  = in_sb ? (32'd0 - rs2) : rs2;
    assign bypass = (rs2 == 32'd0) && (BYPASS_DIV0 != 0);

    // Remainder takes the dividend's sign, quotient the XOR of both signs.
    assign neg_fix = op_q[1] ? sa : (sa ^ sb);

    always_comb begin
        fix_value = neg_fix ? div_rem_neg : div_rem;
        if (div0) begin
            fix_value = op_q[1] ? dividend : 32'hFFFF_FFFF;
        end
    end

    assign mux_div_rem = op_q[1] ? `MUX_DIV_REM_R : `MUX_DIV_REM_Z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = bypass ? S_FIX : S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (cnt == 5'd31) begin
                        state_nxt = S_FIX;
                    end
                end
                S_FIX:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 32'd0;
            R        <= 32'd0;
            D        <= 63'd0;
            Z        <= 32'd0;
            cnt      <= 5'd0;
            op_q     <= 2'b00;
            sa       <= 1'b0;
            sb       <= 1'b0;
            div0     <= 1'b0;
            dividend <= 32'd0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // The done cycle is spent in IDLE, so busy drops only
                        // when no back-to-back start arrives.
                        busy <= start;
                        if (start) begin
                            op_q     <= op;
                            sa       <= in_sa;
                            sb       <= in_sb;
                            div0     <= (rs2 == 32'd0);
                            dividend <= rs1;
                            R        <= abs_a;
                            D        <= {abs_b, 31'd0};
                            Z        <= 32'd0;
                            cnt      <= 5'd0;
                        end
                    end
                    S_DIVIDE: begin
                        if (!sub_neg) begin
                            R <= sub_result;
                        end
                        Z   <= {Z[30:0], ~sub_neg};
                        D   <= D >> 1;
                        cnt <= cnt + 5'd1;
                    end
                    S_FIX: begin
                        result <= fix_value;
                        done   <= 1'b1;
                    end
                    default: busy <= 1'b0;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_m_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_div_seq
// Description : Self-checking bench for m_div_seq with an m_alu stand-in and an
//               arithmetic reference model of RV32M division.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif
`ifndef MUX_DIV_REM_Z
`define MUX_DIV_REM_Z 1'b0
`endif
`ifndef MUX_DIV_REM_R
`define MUX_DIV_REM_R 1'b1
`endif

module tb_m_div_seq;

    localparam int BYP = 1;

    logic                           clk;
    logic                           reset;
    logic                           start;
    logic [1:0]                     op;
    logic [31:0]                    rs1;
    logic [31:0]                    rs2;
    logic                           kill;
    logic                           busy;
    logic                           done;
    logic [31:0]                    result;
    logic [31:0]                    R;
    logic [62:0]                    D;
    logic [31:0]                    Z;
    logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem;
    logic [31:0]                    sub_result;
    logic                           sub_neg;
    logic [31:0]                    div_rem;
    logic [31:0]                    div_rem_neg;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result;

    m_div_seq #(.BYPASS_DIV0(BYP)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs1         (rs1),
        .rs2         (rs2),
        .kill        (kill),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .R           (R),
        .D           (D),
        .Z           (Z),
        .mux_div_rem (mux_div_rem),
        .sub_result  (sub_result),
        .sub_neg     (sub_neg),
        .div_rem     (div_rem),
        .div_rem_neg (div_rem_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // m_alu stand-in: full-width subtract and the result select/negate path.
    logic [63:0] diff;
    assign diff        = {32'd0, R} - {1'b0, D};
    assign sub_result  = diff[31:0];
    assign sub_neg     = diff[63];
    assign div_rem     = (mux_div_rem == `MUX_DIV_REM_R) ? R : Z;
    assign div_rem_neg = 32'd0 - div_rem;

    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return f[1] ? r[31:0] : q[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation and waits (bounded) for done; optionally pulses a
    // stray start mid-operation which must be ignored.
    task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_at);
        int          n;
        int          exp_lat;
        logic [31:0] exp_r;
        string       tag;
        exp_r   = ref_result(f, a, b);
        exp_lat = (b == 32'd0 && BYP != 0) ? 1 : 33;
        tag     = $sformatf("op%0d %h/%h", f, a, b);
        start = 1'b1;
        op    = f;
        rs1   = a;
        rs2   = b;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        rs1   = $urandom;
        rs2   = $urandom;
        n     = 0;
        chk({tag, " busy_after_start"}, 64'(busy), 64'(1));
        chk({tag, " done_after_start"}, 64'(done), 64'(0));
        chk({tag, " mux"}, 64'(mux_div_rem), 64'(f[1] ? `MUX_DIV_REM_R : `MUX_DIV_REM_Z));
        while (!done && n < 40) begin
            start = (n == glitch_at);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " result"}, 64'(result), 64'(exp_r));
        chk({tag, " busy_in_done"}, 64'(busy), 64'(1));
        last_result = exp_r;
    endtask

    initial begin
        int          dones;
        logic [1:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        rs1   = 32'd0;
        rs2   = 32'd0;
        last_result = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset result", 64'(result), 64'(0));
        chk("reset R", 64'(R), 64'(0));
        chk("reset D", 64'(D), 64'(0));
        chk("reset Z", 64'(Z), 64'(0));
        chk("reset mux", 64'(mux_div_rem), 64'(`MUX_DIV_REM_Z));
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases, issued back-to-back.
        do_op(2'b00, 32'd100, 32'd7, -1);
        do_op(2'b10, 32'd100, 32'd7, -1);
        do_op(2'b00, 32'hFFFF_FF9C, 32'd7, -1);
        do_op(2'b10, 32'hFFFF_FF9C, 32'd7, -1);
        do_op(2'b10, 32'd100, 32'hFFFF_FFF9, -1);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd2, -1);
        do_op(2'b11, 32'hFFFF_FFFF, 32'd2, -1);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op(2'b00, 32'hFFFF_FFFB, 32'd0, -1);
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, -1);
        do_op(2'b01, 32'd9, 32'd0, -1);

        // Stray start in the middle of DIVIDE.
        do_op(2'b00, 32'd1000, 32'd7, 5);

        // kill has priority over start while idle.
        @(posedge clk); #1;
        start = 1'b1;
        kill  = 1'b1;
        rs1   = 32'd50;
        rs2   = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        kill  = 1'b0;
        chk("kill_vs_start busy", 64'(busy), 64'(0));

        // kill at step 10.
        start = 1'b1;
        op    = 2'b00;
        rs1   = 32'd12345;
        rs2   = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill busy", 64'(busy), 64'(0));
        dones = 0;
        repeat (40) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        chk("kill no_done", 64'(dones), 64'(0));
        chk("kill result_held", 64'(result), 64'(last_result));

        // Reset at step 20 takes effect without waiting for a clock edge.
        start = 1'b1;
        op    = 2'b10;
        rs1   = 32'd777;
        rs2   = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("midreset busy", 64'(busy), 64'(0));
        chk("midreset done", 64'(done), 64'(0));
        chk("midreset result", 64'(result), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_op(2'b00, 32'd100, 32'd7, -1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rf = 2'($urandom);
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'd0 - 32'($urandom_range(1, 100));
                4:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            do_op(rf, ra, rb, -1);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
